mc_ctrl_fsm: RTL and testbench

- Main control FSM for the multicycle MIPS CPU.
- Sequences the shared datapath registers (PC, IR, MDR, A/B, ALUOut) through fetch, decode, execute, memory and writeback.
- Produces every datapath enable and mux select.
- Waits on a single shared memory port that uses a ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 45 ++++
 rtl/mc_ctrl_perf.sv | 24 ++
 rtl/mc_ctrl_fsm.sv | 142 ++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// state numbering, opcode values and datapath mux select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_perf.sv
// Cycle and retired-instruction counters for the control FSM.
// Only instantiated when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_perf
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycle_en,
    input  logic        instr_en,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (cycle_en) cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_en) instr_cnt <= instr_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS datapath.
// Optional perf counters enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic [ST_W-1:0] state_o,
    output logic            trap
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt
`endif
);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        is_mem_op(opcode):   state <= S_MEM_ADDR;
                        (opcode == OP_R):    state <= S_EXEC;
                        (opcode == OP_BEQ):  state <= S_BRANCH;
                        (opcode == OP_J):    state <= S_JUMP;
                        (opcode == OP_ADDI): state <= S_ADDI_EX;
                        default:             state <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_EXEC:     state <= S_R_WB;
                S_ADDI_EX:  state <= S_ADDI_WB;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Memory requests are held steady across wait states; only
    // FETCH's IR/PC loads are qualified by mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        trap          = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: reg_write = 1'b1;
            S_TRAP:    trap = 1'b1;
            default: ;
        endcase
    end

    assign state_o = ST_W'(state);

`ifdef MC_CTRL_PERF_CNT_EN
    mc_ctrl_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cycle_en  (state != S_TRAP),
        .instr_en  ((state == S_FETCH) && mem_ready),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table
// through a scoreboard queue, plus reset and trap sequences.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        ctl_t       ctl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state_o;
    logic        trap;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state_o       (state_o),
        .trap          (trap)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, trap};

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    ctl_t F_WAIT, F_RDY, DEC, MADDR, MRD, MWB, MWR;
    ctl_t EXEC, RWB, BR, JMP, AEX, AWB, TRP;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JP   = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ILL  = 6'b111111;

    function automatic ctl_t mk(
        input logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa,
        input logic [1:0] sb, op, ps,
        input logic tr
    );
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, tr};
    endfunction

    function automatic void add(input logic [5:0] op, input logic rdy,
                                input logic [3:0] st, input ctl_t c);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = c;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string tag, input int idx,
                       input logic [3:0] est, input ctl_t ec);
        n_chk++;
        if (state_o !== est) begin
            n_fail++;
            $display("FAIL %s[%0d] state: got %0d, want %0d",
                     tag, idx, state_o, est);
        end
        n_chk++;
        if (act !== ec) begin
            n_fail++;
            $display("FAIL %s[%0d] ctl: got %h, want %h",
                     tag, idx, act, ec);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        vec_t e;
        opcode    = v.op;
        mem_ready = v.rdy;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp(tag, idx, e.st, e.ctl);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], tag, i);
        vecs.delete();
    endtask

    initial begin
        F_WAIT = mk(0,0,0,1,0,0,0,0,0,0, 2'd1, 2'd0, 2'd0, 0);
        F_RDY  = mk(1,0,0,1,0,1,0,0,0,0, 2'd1, 2'd0, 2'd0, 0);
        DEC    = mk(0,0,0,0,0,0,0,0,0,0, 2'd3, 2'd0, 2'd0, 0);
        MADDR  = mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, 2'd0, 0);
        MRD    = mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
        MWB    = mk(0,0,0,0,0,0,1,0,1,0, 2'd0, 2'd0, 2'd0, 0);
        MWR    = mk(0,0,1,0,1,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
        EXEC   = mk(0,0,0,0,0,0,0,0,0,1, 2'd0, 2'd2, 2'd0, 0);
        RWB    = mk(0,0,0,0,0,0,0,1,1,0, 2'd0, 2'd0, 2'd0, 0);
        BR     = mk(0,1,0,0,0,0,0,0,0,1, 2'd0, 2'd1, 2'd1, 0);
        JMP    = mk(1,0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd2, 0);
        AEX    = mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, 2'd0, 0);
        AWB    = mk(0,0,0,0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd0, 0);
        TRP    = mk(0,0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 1);

        // lw: fetch wait then 5-cycle instruction
        add(LW, 0, 0, F_WAIT);
        add(LW, 1, 0, F_RDY);  add(LW, 1, 1, DEC);
        add(LW, 1, 2, MADDR);  add(LW, 1, 3, MRD);
        add(LW, 1, 4, MWB);
        // sw: MEM_WR stalled 3 cycles
        add(SW, 1, 0, F_RDY);  add(SW, 1, 1, DEC);
        add(SW, 1, 2, MADDR);  add(SW, 0, 5, MWR);
        add(SW, 0, 5, MWR);    add(SW, 0, 5, MWR);
        add(SW, 1, 5, MWR);
        // R-type, mem_ready low where it must be ignored
        add(RT, 1, 0, F_RDY);  add(RT, 0, 1, DEC);
        add(RT, 0, 6, EXEC);   add(RT, 0, 7, RWB);
        add(BEQ, 1, 0, F_RDY); add(BEQ, 1, 1, DEC);
        add(BEQ, 1, 8, BR);
        add(JP, 1, 0, F_RDY);  add(JP, 1, 1, DEC);
        add(JP, 1, 9, JMP);
        add(ADDI, 1, 0, F_RDY); add(ADDI, 1, 1, DEC);
        add(ADDI, 1, 10, AEX);  add(ADDI, 1, 11, AWB);
        add(ILL, 1, 0, F_RDY); add(ILL, 1, 1, DEC);
        for (int i = 0; i < 10; i++) add(RT, i[0], 12, TRP);

        rst_n = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
        #2 rst_n = 1'b0;
        #1 cmp("reset", 0, 4'd0, F_WAIT);
        @(posedge clk); #1 rst_n = 1'b1;

        run_vecs("seq");

        // trap is cleared only by reset, asynchronously
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1 cmp("trap_clr", 0, 4'd0, F_WAIT);
        @(posedge clk); #1 rst_n = 1'b1;

        // reset in the middle of a MEM_RD wait
        add(LW, 1, 0, F_RDY); add(LW, 1, 1, DEC);
        add(LW, 1, 2, MADDR); add(LW, 0, 3, MRD);
        add(LW, 0, 3, MRD);
        run_vecs("lw_wait");
        #2 rst_n = 1'b0;
        #1 cmp("rst_mid_rd", 0, 4'd0, F_WAIT);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) add(LW, 0, 0, F_WAIT);
        run_vecs("post_rst");

`ifdef MC_CTRL_PERF_CNT_EN
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            add(RT, 1, 0, F_RDY); add(RT, 1, 1, DEC);
            add(RT, 1, 6, EXEC);  add(RT, 1, 7, RWB);
        end
        run_vecs("perf");
        n_chk++;
        if (instr_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL instr_cnt: got %0d, want 3", instr_cnt);
        end
        n_chk++;
        if (cycle_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL cycle_cnt: got %0d, want 12", cycle_cnt);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
